// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall unit beside the ID/EX register.
// Selects are registered so they are valid while the checked instruction is in EX.
module hazard_forward_unit #(
    parameter int NUM_SRC  = 2,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NUM_SRC*AW-1:0]  id_rs,
    input  logic [AW-1:0]          idex_rd,
    input  logic                   idex_regwrite,
    input  logic                   idex_memread,
    input  logic [AW-1:0]          exmem_rd,
    input  logic                   exmem_regwrite,
    input  logic                   flush,
    output logic [NUM_SRC*2-1:0]   fwd_sel,
    output logic                   stall,
    output logic                   bubble,
    output logic [CNT_W-1:0]       stall_count
);

    typedef enum logic {RUN, HOLD} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [NUM_SRC*2-1:0]   fwd_sel_q, fwd_sel_d, sel_calc;
    logic [CNT_W-1:0]       stall_count_q, stall_count_d;
    logic [NUM_SRC-1:0]     ex_hit, mem_hit;
    logic                   hazard;

    // x0 is never forwarded: a nonzero rs equal to rd implies rd is nonzero too.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        assign ex_hit[i]  = id_valid && (id_rs[i*AW +: AW] != '0) &&
                            (id_rs[i*AW +: AW] == idex_rd) && idex_regwrite;
        assign mem_hit[i] = id_valid && (id_rs[i*AW +: AW] != '0) &&
                            (id_rs[i*AW +: AW] == exmem_rd) && exmem_regwrite;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        sel_calc = '0;
        hazard   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_hit[i]) begin
                sel_calc[i*2 +: 2] = 2'b10;
                if (idex_memread) hazard = 1'b1;
            end else if (mem_hit[i]) begin
                sel_calc[i*2 +: 2] = 2'b01;
            end
        end
    end

    // NOTE: asynchronous active-high reset; sequential state uses non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            fwd_sel_q     <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fwd_sel_q     <= fwd_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state_d = HOLD;
                        cnt_d   = 3'(LOAD_LAT - 1);
                    end
                end
                HOLD: begin
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Flush kills the ID instruction, so it overrides both a fresh hazard and HOLD.
    always_comb begin
        stall  = !rst && !flush && ((state_q == HOLD) || hazard);
        bubble = stall;
    end

    always_comb begin
        fwd_sel_d     = (flush || stall) ? '0 : sel_calc;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign fwd_sel     = fwd_sel_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: three instances (LOAD_LAT 1, LOAD_LAT 3,
// 2-bit counter) share one stimulus stream and are compared against a bubble-budget model.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [9:0] id_rs;
    logic [4:0] idex_rd, exmem_rd;
    logic       idex_regwrite, idex_memread, exmem_regwrite, flush;

    logic [3:0]  fwd_l1, fwd_l3, fwd_sat;
    logic        stall_l1, stall_l3, stall_sat;
    logic        bub_l1, bub_l3, bub_sat;
    logic [15:0] cnt_l1, cnt_l3;
    logic [1:0]  cnt_sat;

    always #5 clk = ~clk;

    hazard_forward_unit #(.NUM_SRC(2), .AW(5), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .flush(flush),
        .fwd_sel(fwd_l1), .stall(stall_l1), .bubble(bub_l1), .stall_count(cnt_l1));

    hazard_forward_unit #(.NUM_SRC(2), .AW(5), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .flush(flush),
        .fwd_sel(fwd_l3), .stall(stall_l3), .bubble(bub_l3), .stall_count(cnt_l3));

    hazard_forward_unit #(.NUM_SRC(2), .AW(5), .LOAD_LAT(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .flush(flush),
        .fwd_sel(fwd_sat), .stall(stall_sat), .bubble(bub_sat), .stall_count(cnt_sat));

    logic [2:0]       stall_v, bub_v;
    logic [2:0][3:0]  fwd_v;
    logic [2:0][15:0] cnt_v;
    assign stall_v = {stall_sat, stall_l3, stall_l1};
    assign bub_v   = {bub_sat, bub_l3, bub_l1};
    assign fwd_v   = {fwd_sat, fwd_l3, fwd_l1};
    assign cnt_v   = {{14'd0, cnt_sat}, cnt_l3, cnt_l1};

    typedef struct {
        logic [2:0]       stall;
        logic [2:0][3:0]  fwd;
        logic [2:0][15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model: remaining bubbles owed per instance, plus expected registered outputs.
    int lat[3]  = '{1, 3, 1};
    int maxc[3] = '{65535, 65535, 3};
    int rem[3];
    int cnt_m[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            rem[j]   = 0;
            cnt_m[j] = 0;
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] xrd, input logic xrw, input logic xmr,
                         input logic [4:0] mrd, input logic mrw, input logic fl);
        logic [4:0] rs [2];
        logic [3:0] sel;
        logic       haz, ex, mem, st;
        exp_t       e;
        @(negedge clk);
        id_valid = v; id_rs = {rs2, rs1};
        idex_rd = xrd; idex_regwrite = xrw; idex_memread = xmr;
        exmem_rd = mrd; exmem_regwrite = mrw; flush = fl;
        #1;
        rs[0] = rs1; rs[1] = rs2;
        sel = '0; haz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ex  = v && rs[k] != 0 && rs[k] == xrd && xrw;
            mem = v && rs[k] != 0 && rs[k] == mrd && mrw;
            sel[k*2 +: 2] = ex ? 2'b10 : (mem ? 2'b01 : 2'b00);
            if (ex && xmr) haz = 1'b1;
        end
        for (int j = 0; j < 3; j++) begin
            st = !fl && (rem[j] > 0 || haz);
            if (fl)              rem[j] = 0;
            else if (rem[j] > 0) rem[j] = rem[j] - 1;
            else if (haz)        rem[j] = lat[j] - 1;
            if (st && cnt_m[j] < maxc[j]) cnt_m[j]++;
            e.stall[j] = st;
            e.fwd[j]   = (fl || st) ? 4'h0 : sel;
            e.cnt[j]   = 16'(cnt_m[j]);
        end
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Async reset pulse between edges, while the LOAD_LAT=3 instance may be holding.
    task automatic reset_pulse();
        @(negedge clk);
        id_valid = 1'b0; flush = 1'b0;
        #1;
        check("pre_rst_stall_l3", {31'd0, stall_l3}, {31'd0, rem[1] > 0});
        rst = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("rst_pulse_stall%0d", j), {31'd0, stall_v[j]}, 32'd0);
            check($sformatf("rst_pulse_fwd%0d", j), {28'd0, fwd_v[j]}, 32'd0);
            check($sformatf("rst_pulse_cnt%0d", j), {16'd0, cnt_v[j]}, 32'd0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t it;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() != 0) begin
                it = sb.pop_front();
                for (int j = 0; j < 3; j++) begin
                    check($sformatf("stall%0d", j), {31'd0, stall_v[j]}, {31'd0, it.stall[j]});
                    check($sformatf("bubble%0d", j), {31'd0, bub_v[j]}, {31'd0, it.stall[j]});
                end
                @(posedge clk);
                #1;
                for (int j = 0; j < 3; j++) begin
                    check($sformatf("fwd_sel%0d", j), {28'd0, fwd_v[j]}, {28'd0, it.fwd[j]});
                    check($sformatf("stall_count%0d", j), {16'd0, cnt_v[j]}, {16'd0, it.cnt[j]});
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        rst = 1'b1;
        id_valid = 1'b1; id_rs = {5'd0, 5'd3};
        idex_rd = 5'd3; idex_regwrite = 1'b1; idex_memread = 1'b1;
        exmem_rd = 5'd0; exmem_regwrite = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("reset_stall%0d", j), {31'd0, stall_v[j]}, 32'd0);
            check($sformatf("reset_fwd%0d", j), {28'd0, fwd_v[j]}, 32'd0);
            check($sformatf("reset_cnt%0d", j), {16'd0, cnt_v[j]}, 32'd0);
        end
        @(negedge clk);
        id_valid = 1'b0;
        rst = 1'b0;

        // Directed cases: EX forward, priority, x0, MEM forward.
        drive(1, 5'd5, 5'd6, 5'd5, 1, 0, 5'd0, 0, 0);
        drive(1, 5'd7, 5'd0, 5'd7, 1, 0, 5'd7, 1, 0);
        drive(1, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0);
        drive(1, 5'd0, 5'd9, 5'd0, 0, 0, 5'd9, 1, 0);
        // Load-use, then the advanced pipeline forwarding from MEM/WB.
        drive(1, 5'd3, 5'd0, 5'd3, 1, 1, 5'd0, 0, 0);
        drive(1, 5'd3, 5'd0, 5'd3, 0, 0, 5'd3, 1, 0);
        drive(1, 5'd3, 5'd0, 5'd3, 0, 0, 5'd3, 1, 0);
        idle();
        // Flush in the second stall cycle of a LOAD_LAT=3 hazard.
        drive(1, 5'd4, 5'd0, 5'd4, 1, 1, 5'd0, 0, 0);
        drive(1, 5'd4, 5'd0, 5'd4, 1, 1, 5'd0, 0, 1);
        drive(1, 5'd4, 5'd0, 5'd0, 0, 0, 5'd4, 1, 0);
        idle();
        // Async reset mid-HOLD.
        drive(1, 5'd0, 5'd2, 5'd2, 1, 1, 5'd0, 0, 0);
        reset_pulse();
        idle();
        // Continuous hazard saturates the 2-bit counter.
        repeat (5) drive(1, 5'd6, 5'd6, 5'd6, 1, 1, 5'd0, 0, 0);
        repeat (3) idle();

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0));
        end
        repeat (3) idle();

        repeat (3) @(posedge clk);
        #2;
        check("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
